// File: rtl/fir_channel_scheduler_if.sv
// Handshake bundle between the two sample sources, the shared FIR core and the result sink.
// The scheduler takes the master view; the surrounding environment takes the slave view.
interface fir_channel_scheduler_if #(
   parameter int DW = 16,
   parameter int RW = 36
);
   logic          s0_valid;
   logic [DW-1:0] s0_data;
   logic          s0_ready;
   logic          s1_valid;
   logic [DW-1:0] s1_data;
   logic          s1_ready;
   logic          core_start;
   logic [DW-1:0] core_sample;
   logic          core_ch;
   logic          core_done;
   logic [RW-1:0] core_result;
   logic          m_valid;
   logic [RW-1:0] m_data;
   logic          m_ch;
   logic          m_ready;
   logic          busy;
   logic          err;

   modport master (
      input  s0_valid, s0_data, s1_valid, s1_data, core_done, core_result, m_ready,
      output s0_ready, s1_ready, core_start, core_sample, core_ch, m_valid, m_data, m_ch,
             busy, err
   );

   modport slave (
      output s0_valid, s0_data, s1_valid, s1_data, core_done, core_result, m_ready,
      input  s0_ready, s1_ready, core_start, core_sample, core_ch, m_valid, m_data, m_ch,
             busy, err
   );
endinterface

// File: rtl/fir_channel_scheduler.sv
// Two-channel round-robin front end for a single shared FIR core: one sample in flight,
// results returned tagged with their channel, sticky error on a core that never answers.
module fir_channel_scheduler #(
   parameter int DW      = 16,
   parameter int RW      = 36,
   parameter int TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   fir_channel_scheduler_if.master bus
);
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t        state_r;
   logic [CW-1:0] cnt_r;
   logic          last_r;
   logic          s0_ready_r;
   logic          s1_ready_r;
   logic          core_start_r;
   logic [DW-1:0] core_sample_r;
   logic          core_ch_r;
   logic          m_valid_r;
   logic [RW-1:0] m_data_r;
   logic          m_ch_r;
   logic          busy_r;
   logic          err_r;

   logic          any_valid_s;
   logic          grant_s;
   logic          acc0_s;
   logic          acc1_s;

   assign acc0_s = s0_ready_r & bus.s0_valid;
   assign acc1_s = s1_ready_r & bus.s1_valid;

   // Round-robin pick among the channels valid right now; a tie goes to the one not served last.
   always_comb begin
      any_valid_s = bus.s0_valid | bus.s1_valid;
      if (bus.s0_valid && bus.s1_valid) begin
         grant_s = ~last_r;
      end else if (bus.s1_valid) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
   end

   // Scheduler FSM; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         cnt_r         <= '0;
         last_r        <= 1'b1;
         s0_ready_r    <= 1'b0;
         s1_ready_r    <= 1'b0;
         core_start_r  <= 1'b0;
         core_sample_r <= '0;
         core_ch_r     <= 1'b0;
         m_valid_r     <= 1'b0;
         m_data_r      <= '0;
         m_ch_r        <= 1'b0;
         busy_r        <= 1'b0;
         err_r         <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (acc0_s || acc1_s) begin
                  core_sample_r <= acc1_s ? bus.s1_data : bus.s0_data;
                  core_ch_r     <= acc1_s;
                  s0_ready_r    <= 1'b0;
                  s1_ready_r    <= 1'b0;
                  core_start_r  <= 1'b1;
                  busy_r        <= 1'b1;
                  state_r       <= ISSUE;
               end else begin
                  s0_ready_r <= any_valid_s & ~grant_s;
                  s1_ready_r <= any_valid_s & grant_s;
               end
            end
            ISSUE: begin
               core_start_r <= 1'b0;
               cnt_r        <= '0;
               state_r      <= WAIT;
            end
            WAIT: begin
               // A done arriving on the last permitted cycle still beats the timeout.
               if (bus.core_done) begin
                  m_data_r  <= bus.core_result;
                  m_ch_r    <= core_ch_r;
                  m_valid_r <= 1'b1;
                  state_r   <= OUT;
               end else if (cnt_r == TO_LAST) begin
                  cnt_r   <= cnt_r + CW'(1);
                  err_r   <= 1'b1;
                  last_r  <= core_ch_r;
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            OUT: begin
               if (bus.m_ready) begin
                  m_valid_r <= 1'b0;
                  last_r    <= m_ch_r;
                  busy_r    <= 1'b0;
                  state_r   <= IDLE;
               end else begin
                  m_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r      <= IDLE;
               s0_ready_r   <= 1'b0;
               s1_ready_r   <= 1'b0;
               core_start_r <= 1'b0;
               m_valid_r    <= 1'b0;
               busy_r       <= 1'b0;
            end
         endcase
      end
   end

   assign bus.s0_ready    = s0_ready_r;
   assign bus.s1_ready    = s1_ready_r;
   assign bus.core_start  = core_start_r;
   assign bus.core_sample = core_sample_r;
   assign bus.core_ch     = core_ch_r;
   assign bus.m_valid     = m_valid_r;
   assign bus.m_data      = m_data_r;
   assign bus.m_ch        = m_ch_r;
   assign bus.busy        = busy_r;
   assign bus.err         = err_r;
endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Self-checking bench for fir_channel_scheduler: plays the sample sources, the FIR core and
// the result sink; expected results are queued at stimulus time and compared at the output.
module tb_fir_channel_scheduler;
   localparam int DW      = 16;
   localparam int RW      = 36;
   localparam int TIMEOUT = 255;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;
   bit   last_g = 1'b1;
   bit   err_m  = 1'b0;
   logic [RW:0] sb_q[$];

   fir_channel_scheduler_if #(.DW(DW), .RW(RW)) bus ();

   fir_channel_scheduler #(.DW(DW), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_accept(output bit ok, output bit ch);
      ok = 1'b0;
      ch = 1'b0;
      for (int n = 0; n < 8 && !ok; n++) begin
         check_eq("ready_onehot", bus.s0_ready & bus.s1_ready, 0);
         if ((bus.s0_ready && bus.s0_valid) || (bus.s1_ready && bus.s1_valid)) begin
            ok = 1'b1;
            ch = bus.s1_ready;
         end else begin
            tick();
         end
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_busy"}, bus.busy, 0);
      check_eq({tag, "_core_start"}, bus.core_start, 0);
      check_eq({tag, "_m_valid"}, bus.m_valid, 0);
      check_eq({tag, "_ready"}, {bus.s0_ready, bus.s1_ready}, 0);
   endtask

   task automatic send(input bit v0, input bit v1, input logic [DW-1:0] d0,
                       input logic [DW-1:0] d1, input int dly, input logic [RW-1:0] res,
                       input int bp, input bit keep);
      bit ok, ch, exp_ch;
      logic [DW-1:0] exp_smp;
      logic [RW:0] e;
      exp_ch  = (v0 && v1) ? ~last_g : v1;
      exp_smp = exp_ch ? d1 : d0;
      bus.s0_valid = v0;
      bus.s1_valid = v1;
      bus.s0_data  = d0;
      bus.s1_data  = d1;
      wait_accept(ok, ch);
      check_eq("accept", ok, 1);
      if (!ok) begin
         bus.s0_valid = 1'b0;
         bus.s1_valid = 1'b0;
         return;
      end
      check_eq("grant_ch", ch, exp_ch);
      sb_q.push_back({exp_ch, res});
      tick();
      if (!keep) begin
         bus.s0_valid = 1'b0;
         bus.s1_valid = 1'b0;
      end
      check_eq("core_start", bus.core_start, 1);
      check_eq("core_sample", bus.core_sample, exp_smp);
      check_eq("core_ch", bus.core_ch, exp_ch);
      check_eq("ready_in_issue", {bus.s0_ready, bus.s1_ready}, 0);
      check_eq("busy_issue", bus.busy, 1);
      for (int i = 0; i < dly; i++) tick();
      check_eq("core_start_pulse", bus.core_start, 0);
      check_eq("sample_stable", bus.core_sample, exp_smp);
      check_eq("ch_stable", bus.core_ch, exp_ch);
      check_eq("m_valid_early", bus.m_valid, 0);
      bus.core_done   = 1'b1;
      bus.core_result = res;
      tick();
      bus.core_done   = 1'b0;
      bus.core_result = RW'($urandom);
      check_eq("m_valid_rise", bus.m_valid, 1);
      for (int i = 0; i < bp; i++) begin
         check_eq("bp_m_valid", bus.m_valid, 1);
         check_eq("bp_m_data", bus.m_data, res);
         check_eq("bp_ready_low", {bus.s0_ready, bus.s1_ready}, 0);
         tick();
      end
      bus.m_ready = 1'b1;
      check_eq("sb_depth", sb_q.size(), 1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_eq("m_data", bus.m_data, e[RW-1:0]);
         check_eq("m_ch", bus.m_ch, e[RW]);
      end
      tick();
      bus.m_ready = 1'b0;
      check_eq("m_valid_drop", bus.m_valid, 0);
      check_eq("busy_done", bus.busy, 0);
      check_eq("err", bus.err, err_m);
      last_g = exp_ch;
   endtask

   task automatic run_timeout(input bit ch, input logic [DW-1:0] d);
      bit ok, gch;
      int n;
      bus.s0_valid = ~ch;
      bus.s1_valid = ch;
      bus.s0_data  = d;
      bus.s1_data  = d;
      wait_accept(ok, gch);
      check_eq("to_accept", ok, 1);
      check_eq("to_grant", gch, ch);
      tick();
      bus.s0_valid = 1'b0;
      bus.s1_valid = 1'b0;
      check_eq("to_core_start", bus.core_start, 1);
      n = 0;
      while (bus.err == 1'b0 && n < 400) begin
         tick();
         n++;
      end
      check_eq("timeout_cycles", n, TIMEOUT + 1);
      check_eq("to_busy", bus.busy, 0);
      check_eq("to_m_valid", bus.m_valid, 0);
      err_m  = 1'b1;
      last_g = ch;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok, gch;
      rst = 1'b1;
      bus.s0_valid = 1'b0; bus.s1_valid = 1'b0;
      bus.s0_data = '0; bus.s1_data = '0;
      bus.core_done = 1'b0; bus.core_result = '0;
      bus.m_ready = 1'b0;
      tick();
      tick();
      check_idle_outputs("rst");
      check_eq("rst_err", bus.err, 0);
      check_eq("rst_core_sample", bus.core_sample, 0);
      check_eq("rst_m_data", {bus.m_data, bus.m_ch, bus.core_ch}, 0);
      rst = 1'b0;
      tick();
      check_idle_outputs("post_rst");
      check_eq("post_rst_err", bus.err, 0);

      // Stray done while idle.
      bus.core_done = 1'b1; bus.core_result = 36'h0_DEAD_BEEF;
      tick();
      bus.core_done = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check_idle_outputs("stray_idle");
         check_eq("stray_idle_m_data", bus.m_data, 0);
         tick();
      end

      send(1'b1, 1'b0, 16'h0123, 16'h0000, 8, 36'h0_000A_BCDE, 0, 1'b0);
      send(1'b0, 1'b1, 16'h0000, 16'h0456, 3, 36'h9_1234_5678, 5, 1'b0);
      for (int i = 0; i < 4; i++)
         send(1'b1, 1'b1, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 2 + i,
              36'h1_0000_0000 + 36'(i * 17), 0, 1'b1);
      bus.s0_valid = 1'b0; bus.s1_valid = 1'b0;
      // Done on the last permitted wait cycle must win over the timeout.
      send(1'b1, 1'b0, 16'h0AAA, 16'h0000, TIMEOUT, 36'h2_2222_2222, 0, 1'b0);
      run_timeout(1'b1, 16'h0BAD);
      send(1'b1, 1'b1, 16'h0C0C, 16'h0D0D, 4, 36'h3_3333_3333, 1, 1'b0);

      // Reset in WAIT, then a stray done.
      bus.s0_valid = 1'b1; bus.s0_data = 16'h0777;
      wait_accept(ok, gch);
      check_eq("rw_accept", ok, 1);
      tick();
      bus.s0_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check_eq("rw_busy_before", bus.busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle_outputs("rw");
      check_eq("rw_err_cleared", bus.err, 0);
      check_eq("rw_data_cleared", {bus.core_sample, bus.core_ch, bus.m_data, bus.m_ch}, 0);
      err_m = 1'b0;
      last_g = 1'b1;
      bus.core_done = 1'b1; bus.core_result = 36'h4_4444_4444;
      tick();
      bus.core_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_idle_outputs("rw_stray");
         tick();
      end
      send(1'b1, 1'b1, 16'h0E0E, 16'h0F0F, 5, 36'h5_5555_5555, 0, 1'b0);

      check_eq("sb_empty", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
